// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to uart_tx/uart_rx),
// data width and the mid-bit sampling offset helper.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP    = 3'd4,
      ST_CLEANUP = 3'd5
   } uart_state_e;

   function automatic int mid_bit_offset(input int clk_per_bit);
      return (clk_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is
// a parameter so idle-high lines come out of reset in their idle state.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined). States: IDLE wait edge |
// START confirm at mid-bit | DATA shift LSB first | PARITY even check | STOP check | CLEANUP pulse
module uart_rx
   import uart_pkg::*;
#(
   parameter int clk_per_bit = 87
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_serial,
   output logic       o_rx_dv,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_active,
   output logic       o_rx_frame_err,
   output logic       o_rx_parity_err
);

   localparam int CNT_W = $clog2(clk_per_bit);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_per_bit - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_bit_offset(clk_per_bit));
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx_serial),
      .o_q   (rx_s)
   );

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             dv_q, dv_d;
   logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic             pmis_q, pmis_d;
   logic             perr_q, perr_d;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pmis_q  <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         dv_q    <= dv_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         pmis_q  <= pmis_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pmis_d  = pmis_q;
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            pmis_d = 1'b0;
`endif
            // A line still low after a bad frame re-enters START right away.
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               pmis_d  = rx_s ^ (^shift_q);
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_CLEANUP;
               if (!rx_s) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (pmis_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  dv_d   = 1'b1;
                  byte_d = shift_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CLEANUP: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign o_rx_dv        = dv_q;
   assign o_rx_byte      = byte_q;
   assign o_rx_frame_err = ferr_q;
   assign o_rx_active    = (state_q == ST_START) || (state_q == ST_DATA) ||
                           (state_q == ST_PARITY) || (state_q == ST_STOP);
`ifdef UART_RX_PARITY_EN
   assign o_rx_parity_err = perr_q;
`else
   assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial frame driver feeds the line, expected
// bytes go to a scoreboard queue and are popped when o_rx_dv pulses.
module tb_uart_rx;

   localparam int CPB = 87;
   localparam int MID = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 3 + MID + 1 + 10 * CPB + 1;
`else
   localparam int LAT = 3 + MID + 1 + 9 * CPB + 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       dv;
   logic [7:0] rx_byte;
   logic       active;
   logic       ferr;
   logic       perr;

   int         compared   = 0;
   int         mismatched = 0;
   int         cyc        = 0;
   int         dv_cnt     = 0;
   int         ferr_cnt   = 0;
   int         perr_cnt   = 0;
   int         last_dv_cyc = 0;
   int         start_cyc  = 0;
   logic       dv_prev    = 1'b0;
   logic       saw_active = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx #(.clk_per_bit(CPB)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_rx_serial     (rx),
      .o_rx_dv         (dv),
      .o_rx_byte       (rx_byte),
      .o_rx_active     (active),
      .o_rx_frame_err  (ferr),
      .o_rx_parity_err (perr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (dv) begin
            dv_cnt++;
            last_dv_cyc = cyc;
            chk("dv_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            chk("dv_pulse_width", 32'(dv_prev), 32'd0);
            chk("dv_err_exclusive", 32'(ferr | perr), 32'd0);
         end
         if (ferr) ferr_cnt++;
         if (perr) perr_cnt++;
         if (active) saw_active = 1'b1;
      end
      dv_prev = dv;
   end

   // Drives one frame starting at a falling edge; rst_bit >= 0 aborts with a
   // one-cycle reset in the middle of that data bit.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input int rst_bit);
      rx = 1'b0;
      start_cyc = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == rst_bit) begin
            repeat (CPB / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            rx  = 1'b1;
            chk("rst_mid_dv", 32'(dv), 32'd0);
            chk("rst_mid_byte", 32'(rx_byte), 32'd0);
            chk("rst_mid_active", 32'(active), 32'd0);
            chk("rst_mid_ferr", 32'(ferr), 32'd0);
            chk("rst_mid_perr", 32'(perr), 32'd0);
            return;
         end
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      repeat (CPB) @(negedge clk);
`else
      if (par) rx = 1'b1;
`endif
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back(b);
      send_frame(b, ^b, 1'b1, -1);
   endtask

   initial begin
      int dv0;
      int fe0;
      int lat;

      repeat (3) @(negedge clk);
      chk("reset_dv", 32'(dv), 32'd0);
      chk("reset_byte", 32'(rx_byte), 32'd0);
      chk("reset_active", 32'(active), 32'd0);
      chk("reset_ferr", 32'(ferr), 32'd0);
      chk("reset_perr", 32'(perr), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single byte, with start-edge and frame latency
      dv0 = dv_cnt;
      rx  = 1'b0;
      exp_q.push_back(8'hA5);
      start_cyc = cyc;
      repeat (2) @(negedge clk);
      chk("start_latency_pre", 32'(active), 32'd0);
      @(negedge clk);
      chk("start_latency_active", 32'(active), 32'd1);
      repeat (CPB - 3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = 8'hA5 >> i;
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = ^8'hA5;
      repeat (CPB) @(negedge clk);
`endif
      rx = 1'b1;
      repeat (CPB + 20) @(negedge clk);
      lat = last_dv_cyc - start_cyc;
      chk("single_dv_count", 32'(dv_cnt - dv0), 32'd1);
      chk("frame_latency_window", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);
      chk("single_active_after", 32'(active), 32'd0);
      chk("single_no_ferr", 32'(ferr_cnt), 32'd0);

      // Back-to-back frames, no idle gap between stop and next start
      dv0 = dv_cnt;
      send_good(8'h00);
      send_good(8'hFF);
      send_good(8'h3C);
      repeat (2 * CPB) @(negedge clk);
      chk("b2b_dv_count", 32'(dv_cnt - dv0), 32'd3);
      chk("b2b_no_ferr", 32'(ferr_cnt), 32'd0);
      chk("b2b_byte_held", 32'(rx_byte), 32'h3C);

      // Glitch rejection
      dv0 = dv_cnt;
      saw_active = 1'b0;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_saw_active", 32'(saw_active), 32'd1);
      chk("glitch_active_low", 32'(active), 32'd0);
      chk("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
      chk("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

      // Framing error: stop bit low
      dv0 = dv_cnt;
      fe0 = ferr_cnt;
      send_frame(8'h5A, ^8'h5A, 1'b0, -1);
      repeat (2 * CPB) @(negedge clk);
      chk("ferr_count", 32'(ferr_cnt - fe0), 32'd1);
      chk("ferr_no_dv", 32'(dv_cnt - dv0), 32'd0);
      chk("ferr_byte_held", 32'(rx_byte), 32'h3C);
      chk("ferr_active_low", 32'(active), 32'd0);

      // Reset during data bit 4, then a clean frame
      dv0 = dv_cnt;
      send_frame(8'hC3, ^8'hC3, 1'b1, 4);
      repeat (2 * CPB) @(negedge clk);
      chk("abort_no_dv", 32'(dv_cnt - dv0), 32'd0);
      send_good(8'hC3);
      repeat (2 * CPB) @(negedge clk);
      chk("after_rst_dv_count", 32'(dv_cnt - dv0), 32'd1);
      chk("after_rst_byte", 32'(rx_byte), 32'hC3);

`ifdef UART_RX_PARITY_EN
      dv0 = dv_cnt;
      send_good(8'h01);
      repeat (2 * CPB) @(negedge clk);
      chk("parity_good_dv", 32'(dv_cnt - dv0), 32'd1);
      chk("parity_good_no_perr", 32'(perr_cnt), 32'd0);
      send_frame(8'h01, 1'b0, 1'b1, -1);
      repeat (2 * CPB) @(negedge clk);
      chk("parity_bad_perr", 32'(perr_cnt), 32'd1);
      chk("parity_bad_no_dv", 32'(dv_cnt - dv0), 32'd1);
`else
      chk("parity_tied_low", 32'(perr_cnt), 32'd0);
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
